seq_bubble_sort: RTL and testbench

//  Sequential sort unit: accepts DIM unsigned words one per handshake and sorts them in

---
 rtl/sort_pkg.sv | 14 +
 rtl/pair_swap.sv | 19 +
 rtl/seq_bubble_sort.sv | 213 +++++++++++++++++++++
 tb/tb_seq_bubble_sort.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sequential sort unit: state encoding and the
// default block geometry used by the top and by the compare/swap chain.
package sort_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DIM   = 8;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/pair_swap.sv
// Combinational compare/swap of one adjacent pair; unsigned, strict greater-than,
// so equal values are never exchanged.
module pair_swap
  import sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/seq_bubble_sort.sv
// Block sorter: load DIM words, odd-even transposition sort one phase per clock,
// drain ascending. Optional early exit on two quiet phases: `SORT_EARLY_EXIT_EN.
module seq_bubble_sort
  import sort_pkg::*;
#(
  parameter int DIM   = DEF_DIM,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(DIM);
  localparam int PW = $clog2(DIM + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIM - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(DIM - 1);

  state_t           state_r, state_s;
  logic [CW-1:0]    ld_cnt_r, ld_cnt_s, rd_cnt_r, rd_cnt_s, rd_nxt_s;
  logic [PW-1:0]    pass_r, pass_s;
  logic             in_ready_r, in_ready_s, out_valid_r, out_valid_s;
  logic             out_last_r, out_last_s, busy_r, busy_s;
  logic [WIDTH-1:0] out_data_r, out_data_s;
  logic [WIDTH-1:0] mem_r [DIM];
  logic [WIDTH-1:0] mem_s [DIM];
  logic [WIDTH-1:0] sort_mem_s [DIM];
  logic [WIDTH-1:0] lo_s [DIM-1];
  logic [WIDTH-1:0] hi_s [DIM-1];
  logic [DIM-2:0]   swp_s, act_s, wr_s;
  logic             ld_fire_s, rd_fire_s, sort_done_s;

  assign ld_fire_s = in_valid & in_ready_r;
  assign rd_fire_s = out_valid_r & out_ready;
  assign rd_nxt_s  = rd_cnt_r + CW'(1);

  // Pair k is active when its parity matches the phase parity
  for (genvar k = 0; k < DIM - 1; k++) begin : g_pair
    pair_swap #(.WIDTH(WIDTH)) u_pair (
      .a    (mem_r[k]),
      .b    (mem_r[k+1]),
      .lo   (lo_s[k]),
      .hi   (hi_s[k]),
      .swap (swp_s[k])
    );
    assign act_s[k] = (pass_r[0] == 1'(k % 2));
    assign wr_s[k]  = act_s[k] & swp_s[k];
  end

  for (genvar j = 0; j < DIM; j++) begin : g_wb
    if (j == 0) begin : g_first
      assign sort_mem_s[j] = wr_s[j] ? lo_s[j] : mem_r[j];
    end else if (j == DIM - 1) begin : g_last
      assign sort_mem_s[j] = wr_s[j-1] ? hi_s[j-1] : mem_r[j];
    end else begin : g_mid
      assign sort_mem_s[j] = wr_s[j-1] ? hi_s[j-1] :
                             wr_s[j]   ? lo_s[j]   : mem_r[j];
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  logic swap_any_s, quiet_r;
  assign swap_any_s  = |(swp_s & act_s);
  assign sort_done_s = (pass_r == PASS_LAST) | (quiet_r & ~swap_any_s);

  // Remembers that the previous phase moved nothing; cleared outside SORT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quiet_r <= 1'b0;
    end else if (state_r == S_SORT) begin
      quiet_r <= ~swap_any_s;
    end else begin
      quiet_r <= 1'b0;
    end
  end
`else
  assign sort_done_s = (pass_r == PASS_LAST);
`endif

  // Next array contents: load write, or one sort phase
  always_comb begin
    mem_s = mem_r;
    case (state_r)
      S_LOAD: begin
        if (ld_fire_s) begin
          mem_s[ld_cnt_r] = in_data;
        end else begin
          mem_s = mem_r;
        end
      end
      S_SORT:  mem_s = sort_mem_s;
      default: mem_s = mem_r;
    endcase
  end

  // Next state, counters and registered output values
  always_comb begin
    state_s     = state_r;
    ld_cnt_s    = ld_cnt_r;
    rd_cnt_s    = rd_cnt_r;
    pass_s      = pass_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    out_data_s  = out_data_r;
    busy_s      = busy_r;
    case (state_r)
      S_LOAD: begin
        if (ld_fire_s && (ld_cnt_r == CNT_LAST)) begin
          state_s    = S_SORT;
          ld_cnt_s   = '0;
          pass_s     = '0;
          in_ready_s = 1'b0;
          busy_s     = 1'b1;
        end else if (ld_fire_s) begin
          ld_cnt_s = ld_cnt_r + CW'(1);
        end else begin
          ld_cnt_s = ld_cnt_r;
        end
      end
      S_SORT: begin
        if (sort_done_s) begin
          state_s     = S_DRAIN;
          pass_s      = '0;
          rd_cnt_s    = '0;
          busy_s      = 1'b0;
          out_valid_s = 1'b1;
          out_last_s  = 1'b0;
          out_data_s  = sort_mem_s[0];
        end else begin
          pass_s = pass_r + PW'(1);
        end
      end
      S_DRAIN: begin
        if (rd_fire_s && (rd_cnt_r == CNT_LAST)) begin
          state_s     = S_LOAD;
          rd_cnt_s    = '0;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          out_data_s  = '0;
          in_ready_s  = 1'b1;
        end else if (rd_fire_s) begin
          rd_cnt_s   = rd_nxt_s;
          out_data_s = mem_r[rd_nxt_s];
          out_last_s = (rd_nxt_s == CNT_LAST);
        end else begin
          rd_cnt_s = rd_cnt_r;
        end
      end
      default: begin
        state_s     = S_LOAD;
        ld_cnt_s    = '0;
        rd_cnt_s    = '0;
        pass_s      = '0;
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        out_data_s  = '0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_LOAD;
      ld_cnt_r    <= '0;
      rd_cnt_r    <= '0;
      pass_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ld_cnt_r    <= ld_cnt_s;
      rd_cnt_r    <= rd_cnt_s;
      pass_r      <= pass_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      out_data_r  <= out_data_s;
      busy_r      <= busy_s;
    end
  end

  // Element storage, kept as registers for parallel pair access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      mem_r <= mem_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_seq_bubble_sort.sv
// Self-checking bench for seq_bubble_sort: directed table, stall/reset sequences,
// and random blocks against a reference sort via an output scoreboard.
module tb_seq_bubble_sort;

  localparam int DIM = 8;
  localparam int W   = 8;
`ifdef SORT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_last, busy;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  seq_bubble_sort #(.DIM(DIM), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef logic [W-1:0] blk_t [DIM];
  typedef struct { logic [W-1:0] d; logic last; } exp_t;
  typedef struct { blk_t din; blk_t dexp; int busy_exp; } vec_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint busy_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pops, stall hold, post-block and drain-phase checks
  logic         prev_stall = 1'b0;
  logic         prev_lasths = 1'b0;
  logic         prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall  = 1'b0;
      prev_lasths = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (prev_lasths) begin
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
      end
      if (out_valid) check("in_ready_in_drain", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %0d, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_last   = out_last;
      prev_lasths = out_valid && out_ready && out_last;
    end
  end

  task automatic load_word(input logic [W-1:0] v);
    int t = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got in_ready=0, want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_block(input blk_t d);
    for (int i = 0; i < DIM; i++) load_word(d[i]);
  endtask

  task automatic push_exp(input blk_t e);
    exp_t x;
    for (int i = 0; i < DIM; i++) begin
      x.d    = e[i];
      x.last = (i == DIM - 1);
      exp_q.push_back(x);
    end
  endtask

  // Reference: selection sort, ascending unsigned
  function automatic blk_t ref_sort(input blk_t d);
    blk_t r = d;
    logic [W-1:0] t;
    for (int i = 0; i < DIM - 1; i++) begin
      int m = i;
      for (int j = i + 1; j < DIM; j++) if (r[j] < r[m]) m = j;
      t = r[i]; r[i] = r[m]; r[m] = t;
    end
    return r;
  endfunction

  // mode 0: always ready; 1: random ready; 2: ready 1-0-0-1 with in_valid pulses
  task automatic wait_drain(input int mode);
    int t = 0;
    int ph = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          in_valid  = 1'(ph % 2);
          in_data   = 8'hAA;
          ph++;
        end
        default: out_ready = 1'b1;
      endcase
    end
    if (t >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t   tbl [4];
  blk_t   blk;
  longint b0;

  initial begin
    tbl[0].din  = '{8'd7, 8'd3, 8'd5, 8'd0, 8'd255, 8'd1, 8'd9, 8'd2};
    tbl[0].dexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd9, 8'd255};
    tbl[0].busy_exp = EE ? -1 : 8;
    tbl[1].din  = '{8'd4, 8'd4, 8'd1, 8'd4, 8'd1, 8'd0, 8'd0, 8'd4};
    tbl[1].dexp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd4, 8'd4, 8'd4, 8'd4};
    tbl[1].busy_exp = EE ? -1 : 8;
    tbl[2].din  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[2].dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[2].busy_exp = EE ? 2 : 8;
    tbl[3].din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tbl[3].dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[3].busy_exp = 8;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      b0 = busy_cyc;
      load_block(tbl[i].din);
      push_exp(tbl[i].dexp);
      wait_drain(0);
      if (tbl[i].busy_exp >= 0) check("busy_cycles", 32'(busy_cyc - b0), 32'(tbl[i].busy_exp));
    end

    // Stalled drain with ignored in_valid pulses
    load_block(tbl[0].din);
    push_exp(tbl[0].dexp);
    wait_drain(2);

    // Reset after a partial load
    for (int i = 0; i < 3; i++) load_word(tbl[1].din[i]);
    rst = 1'b1;
    @(negedge clk);
    check("rst_part_in_ready", 32'(in_ready), 32'd1);
    check("rst_part_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of SORT
    load_block(tbl[0].din);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_sort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_sort_in_ready", 32'(in_ready), 32'd1);
    check("rst_sort_out_valid", 32'(out_valid), 32'd0);
    check("rst_sort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    b0 = busy_cyc;
    load_block(tbl[3].din);
    push_exp(tbl[3].dexp);
    wait_drain(0);
    check("reload_busy_cycles", 32'(busy_cyc - b0), 32'd8);

    // Random blocks against the reference model, random consumer stalls
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < DIM; i++)
        blk[i] = (n % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 3));
      load_block(blk);
      push_exp(ref_sort(blk));
      wait_drain(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
